// File: rtl/muldiv_seq_if.sv
// Request/response bundle between the core and the iterative mul/div sequencer.
interface muldiv_seq_if #(
  parameter int Width = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [Width-1:0] req_a;
  logic [Width-1:0] req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [Width-1:0] resp_result;

  // The core issues requests and consumes results.
  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_result
  );

  // The sequencer accepts requests and produces results.
  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_result
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up afterwards.
module muldiv_seq #(
  parameter int Width       = 32,
  parameter bit FastSpecial = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         kill,
  output logic         busy,
  muldiv_seq_if.slave  bus
);

  localparam int W = 32;

  if (Width != W) begin : g_width_chk
    $error("muldiv_seq: only Width = 32 is supported");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

  localparam logic [2:0] OP_MUL  = 3'b000;
  localparam logic [2:0] OP_MULH = 3'b001;
  localparam logic [2:0] OP_MHSU = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_REM  = 3'b110;

  state_e         state_q, state_d;
  logic [2:0]     op_q, op_d;
  logic           sa_q, sa_d;       // dividend / multiplicand negative
  logic           sb_q, sb_d;       // divisor / multiplier negative
  logic           bz_q, bz_d;       // divisor was zero
  logic           spec_q, spec_d;   // div-by-zero or signed overflow
  logic           fph_q, fph_d;     // FIX sub-phase: 0 = negate, 1 = select
  logic [4:0]     cnt_q, cnt_d;
  logic [W-1:0]   ma_q, ma_d;
  logic [W-1:0]   mb_q, mb_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   res_q, res_d;

  // Request decode: signedness per op, magnitudes, special-case detection.
  logic           in_sa, in_sb, in_bz, in_ovf, in_spec;
  logic [W-1:0]   in_ma, in_mb;
  always_comb begin
    in_sa   = (bus.req_op == OP_MULH) || (bus.req_op == OP_MHSU) ||
              (bus.req_op == OP_DIV)  || (bus.req_op == OP_REM);
    in_sb   = (bus.req_op == OP_MULH) || (bus.req_op == OP_DIV) ||
              (bus.req_op == OP_REM);
    in_sa   = in_sa & bus.req_a[W-1];
    in_sb   = in_sb & bus.req_b[W-1];
    in_ma   = in_sa ? (~bus.req_a + 1'b1) : bus.req_a;
    in_mb   = in_sb ? (~bus.req_b + 1'b1) : bus.req_b;
    in_bz   = (bus.req_b == '0);
    in_ovf  = ((bus.req_op == OP_DIV) || (bus.req_op == OP_REM)) &&
              (bus.req_a == 32'h8000_0000) && (bus.req_b == 32'hFFFF_FFFF);
    in_spec = bus.req_op[2] && (in_bz || in_ovf);
  end

  // One radix-2 iteration. Multiply keeps the multiplier in the low word and
  // shifts the product in from the top; divide shifts the dividend out of the
  // low word into the partial remainder and shifts quotient bits in.
  logic [W:0]     mul_sum, div_sh, div_diff;
  logic           div_ge;
  logic [2*W-1:0] step;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, ma_q} : '0);
    div_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff = div_sh - {1'b0, mb_q};
    div_ge   = ~div_diff[W];
    if (op_q[2])
      step = {(div_ge ? div_diff[W-1:0] : div_sh[W-1:0]), acc_q[W-2:0], div_ge};
    else
      step = {mul_sum, acc_q[W-1:1]};
  end

  // Sign correction and word select. A zero divisor leaves an all-ones
  // quotient, which must not be negated; its remainder is |a| and regains the
  // dividend's sign, so both come out right on the iterative path too.
  logic [2*W-1:0] fixed;
  logic [W-1:0]   hi, lo, sel, spec_res;
  always_comb begin
    hi = acc_q[2*W-1:W];
    lo = acc_q[W-1:0];
    if (op_q[2])
      fixed = {(sa_q ? (~hi + 1'b1) : hi),
               ((sa_q ^ sb_q) && !bz_q ? (~lo + 1'b1) : lo)};
    else
      fixed = (sa_q ^ sb_q) ? (~acc_q + 1'b1) : acc_q;
    if (op_q[2])
      sel = op_q[1] ? hi : lo;
    else
      sel = (op_q == OP_MUL) ? lo : hi;
    if (!op_q[1])
      spec_res = bz_q ? 32'hFFFF_FFFF : 32'h8000_0000;
    else
      spec_res = bz_q ? (sa_q ? (~ma_q + 1'b1) : ma_q) : '0;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    bz_d    = bz_q;
    spec_d  = spec_q;
    fph_d   = fph_q;
    cnt_d   = cnt_q;
    ma_d    = ma_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          sa_d    = in_sa;
          sb_d    = in_sb;
          bz_d    = in_bz;
          spec_d  = in_spec;
          ma_d    = in_ma;
          mb_d    = in_mb;
          acc_d   = {{W{1'b0}}, (bus.req_op[2] ? in_ma : in_mb)};
          cnt_d   = 5'd31;
          fph_d   = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else if (FastSpecial && spec_q) begin
          res_d   = spec_res;
          state_d = DONE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_d = FIX;
        end
      end
      // Negation and word select take separate cycles so the 64-bit negate
      // never feeds the result mux in the same cycle.
      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else if (!fph_q) begin
          acc_d = fixed;
          fph_d = 1'b1;
        end else begin
          res_d   = sel;
          state_d = DONE;
        end
      end
      DONE: begin
        if (kill || bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      spec_q  <= 1'b0;
      fph_q   <= 1'b0;
      cnt_q   <= '0;
      ma_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      bz_q    <= bz_d;
      spec_q  <= spec_d;
      fph_q   <= fph_d;
      cnt_q   <= cnt_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = (state_q == DONE);
  assign bus.resp_result = res_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench: two sequencers (fast special path on / off) share stimulus
// and are checked against hand-computed results and latencies.
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kill = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        resp_ready = 1'b1;
  logic        busy_f, busy_s;
  int          asserts = 0;
  int          fails = 0;

  muldiv_seq_if #(.Width(32)) if_f ();
  muldiv_seq_if #(.Width(32)) if_s ();

  assign if_f.req_valid  = req_valid;
  assign if_f.req_op     = req_op;
  assign if_f.req_a      = req_a;
  assign if_f.req_b      = req_b;
  assign if_f.resp_ready = resp_ready;
  assign if_s.req_valid  = req_valid;
  assign if_s.req_op     = req_op;
  assign if_s.req_a      = req_a;
  assign if_s.req_b      = req_b;
  assign if_s.resp_ready = resp_ready;

  muldiv_seq #(.Width(32), .FastSpecial(1'b1)) u_fast (
    .clk(clk), .rst_n(rst_n), .kill(kill), .busy(busy_f), .bus(if_f));
  muldiv_seq #(.Width(32), .FastSpecial(1'b0)) u_slow (
    .clk(clk), .rst_n(rst_n), .kill(kill), .busy(busy_s), .bus(if_s));

  always #5 clk = ~clk;

  task automatic check_idle(input string name);
    asserts++;
    if (if_f.req_ready !== 1'b1 || if_f.resp_valid !== 1'b0 || busy_f !== 1'b0 ||
        if_s.req_ready !== 1'b1 || if_s.resp_valid !== 1'b0 || busy_s !== 1'b0) begin
      fails++;
      $display("FAIL %s: fast rdy/vld/busy=%b%b%b slow=%b%b%b, required 100",
               name, if_f.req_ready, if_f.resp_valid, busy_f,
               if_s.req_ready, if_s.resp_valid, busy_s);
    end
  endtask

  // Issue one request to both DUTs, then measure latency and result of each.
  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit special,
                        input bit kill_at_accept);
    int lat_f, lat_s, exp_lat_f;
    logic [31:0] r_f, r_s;
    bit busy_ok;
    lat_f = 0; lat_s = 0; r_f = '0; r_s = '0; busy_ok = 1'b1;
    exp_lat_f = special ? 1 : 34;
    for (int i = 0; i < 50 && !(if_f.req_ready && if_s.req_ready); i++) begin
      @(posedge clk); #1;
    end
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; kill = kill_at_accept;
    @(posedge clk); #1;
    req_valid = 1'b0; kill = 1'b0; req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678;
    for (int k = 1; k <= 40; k++) begin
      if (lat_s == 0 && busy_s !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      if (lat_f == 0 && if_f.resp_valid) begin lat_f = k; r_f = if_f.resp_result; end
      if (lat_s == 0 && if_s.resp_valid) begin lat_s = k; r_s = if_s.resp_result; end
    end
    asserts++;
    if (r_f !== exp) begin
      fails++; $display("FAIL %s fast result: got %h, required %h", name, r_f, exp);
    end
    asserts++;
    if (lat_f != exp_lat_f) begin
      fails++; $display("FAIL %s fast latency: got %0d, required %0d", name, lat_f, exp_lat_f);
    end
    asserts++;
    if (r_s !== exp) begin
      fails++; $display("FAIL %s slow result: got %h, required %h", name, r_s, exp);
    end
    asserts++;
    if (lat_s != 34) begin
      fails++; $display("FAIL %s slow latency: got %0d, required 34", name, lat_s);
    end
    asserts++;
    if (!busy_ok) begin
      fails++; $display("FAIL %s busy: dropped before response, required high", name);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset idle");
    asserts++;
    if (if_f.resp_result !== 32'h0 || if_s.resp_result !== 32'h0) begin
      fails++; $display("FAIL reset result: got %h/%h, required 0", if_f.resp_result, if_s.resp_result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    run_op("MUL 6*7",      3'b000, 32'd6,        32'd7,        32'd42,        1'b0, 1'b0);
    run_op("MULH -1*-1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,         1'b0, 1'b0);
    run_op("MULHU ff*ff",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  1'b0, 1'b0);
    run_op("MULHSU -1*2",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF,  1'b0, 1'b0);
    run_op("MUL kill idle",3'b000, 32'd2,        32'd3,        32'd6,         1'b0, 1'b1);
  endtask

  task automatic test_div;
    run_op("DIV -7/2",   3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("REM -7%2",   3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("DIVU 100/7", 3'b101, 32'd100,      32'd7, 32'd14,       1'b0, 1'b0);
    run_op("REMU 100%7", 3'b111, 32'd100,      32'd7, 32'd2,        1'b0, 1'b0);
  endtask

  task automatic test_special;
    run_op("DIVU 5/0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("REM 5%0",      3'b110, 32'd5,        32'd0,        32'd5,        1'b1, 1'b0);
    run_op("DIV -5/0",     3'b100, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1, 1'b0);
    run_op("DIV ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0);
    run_op("REM ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    int lat;
    bit stable;
    lat = 0; stable = 1'b1;
    resp_ready = 1'b0;
    req_op = 3'b101; req_a = 32'd100; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk); #1;
      if (if_f.resp_valid && if_s.resp_valid) lat = k;
    end
    asserts++;
    if (lat != 34) begin
      fails++; $display("FAIL backpressure latency: got %0d, required 34", lat);
    end
    req_op = 3'b000; req_a = 32'd3; req_b = 32'd5; req_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (if_f.resp_valid !== 1'b1 || if_s.resp_valid !== 1'b1 ||
          if_f.resp_result !== 32'd14 || if_s.resp_result !== 32'd14 ||
          if_f.req_ready !== 1'b0 || if_s.req_ready !== 1'b0) stable = 1'b0;
    end
    asserts++;
    if (!stable) begin
      fails++; $display("FAIL backpressure hold: vld=%b%b res=%h/%h rdy=%b%b, required 11 0000000e 00",
                        if_f.resp_valid, if_s.resp_valid, if_f.resp_result, if_s.resp_result,
                        if_f.req_ready, if_s.req_ready);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check_idle("backpressure release");
  endtask

  task automatic test_kill;
    bit seen;
    seen = 1'b0;
    req_op = 3'b000; req_a = 32'd5; req_b = 32'd5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check_idle("kill in CALC");
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (if_f.resp_valid || if_s.resp_valid) seen = 1'b1;
    end
    asserts++;
    if (seen) begin
      fails++; $display("FAIL kill response: got resp_valid, required none");
    end
    run_op("MUL 3*3 after kill", 3'b000, 32'd3, 32'd3, 32'd9, 1'b0, 1'b0);
  endtask

  task automatic test_kill_done;
    resp_ready = 1'b0;
    req_op = 3'b101; req_a = 32'd9; req_b = 32'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    resp_ready = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check_idle("kill in DONE");
  endtask

  task automatic test_async_reset;
    req_op = 3'b000; req_a = 32'd6; req_b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async reset mid-CALC");
    asserts++;
    if (if_f.resp_result !== 32'h0 || if_s.resp_result !== 32'h0) begin
      fails++; $display("FAIL async reset result: got %h/%h, required 0", if_f.resp_result, if_s.resp_result);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("MUL after reset", 3'b000, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_backpressure();
    test_kill();
    test_kill_done();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
